// File: rtl/counter_pkg.sv
// Shared counter definitions: FSM state encoding and default width.
// Imported by the down-counter timer and related datapath counters.
package counter_pkg;

    localparam int unsigned CNT_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } cnt_state_e;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down-counter / timer with one-cycle terminal-count pulse,
// one-shot or auto-reload operation.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   load        strobe: capture load_val into count and reload register
//   load_val    start / reload value (unsigned)
//   en          count enable
//   auto_reload 1 = periodic, 0 = one-shot (sampled at terminal count)
//   count       current count (registered)
//   busy        high while running (registered)
//   tc          terminal-count pulse, one cycle (registered)
//   done        high after one-shot expiry until next load (registered)
module down_counter_timer
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    cnt_state_e       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        done_d   = done_q;

        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            if (load_val == ZERO) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                state_d = RUN;
                done_d  = 1'b0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                RUN: begin
                    if (en) begin
                        if (count_q == ONE) begin
                            tc_d = 1'b1;
                            if (auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                count_d = ZERO;
                                done_d  = 1'b1;
                                state_d = DONE;
                            end
                        end else if (count_q != ZERO) begin
                            count_d = count_q - ONE;
                        end
                    end
                end
                DONE: begin
                    count_d = ZERO;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // busy is decoded from the next state so it lines up with count/tc.
    assign busy_d = (state_d == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign tc    = tc_q;
    assign done  = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer.
// Inputs change 1 ns after each rising edge; outputs checked there too.
module tb_down_counter_timer;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [7:0] load_val;
    logic       en;
    logic       auto_reload;
    logic [7:0] count;
    logic       busy;
    logic       tc;
    logic       done;

    int n_chk;
    int n_fail;
    int tc_seen;

    down_counter_timer #(.WIDTH(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .load_val(load_val),
        .en(en),
        .auto_reload(auto_reload),
        .count(count),
        .busy(busy),
        .tc(tc),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input int c, input int b,
                        input int t, input int d);
        chk({tag, ".count"}, int'(count), c);
        chk({tag, ".busy"}, int'(busy), b);
        chk({tag, ".tc"}, int'(tc), t);
        chk({tag, ".done"}, int'(done), d);
    endtask

    task automatic do_load(input int v, input logic ar, input logic e);
        load = 1'b1;
        load_val = 8'(v);
        auto_reload = ar;
        en = e;
        step();
        load = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        load = 1'b0;
        load_val = '0;
        en = 1'b0;
        auto_reload = 1'b0;
        #2;
        outs("rst", 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        step();
        outs("idle", 0, 0, 0, 0);

        // Reset mid-run takes effect without a clock edge
        do_load(5, 1'b0, 1'b1);
        step();
        step();
        outs("pre_rst", 3, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1 outs("async_rst", 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        en = 1'b1;
        step();
        outs("idle_en", 0, 0, 0, 0);

        // One-shot 3
        do_load(3, 1'b0, 1'b1);
        outs("os_ld", 3, 1, 0, 0);
        step(); outs("os1", 2, 1, 0, 0);
        step(); outs("os2", 1, 1, 0, 0);
        step(); outs("os3", 0, 0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            outs("os_hold", 0, 0, 0, 1);
        end

        // Periodic 4
        do_load(4, 1'b1, 1'b1);
        outs("per_ld", 4, 1, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            step();
            outs("per", (k % 4 == 0) ? 4 : 4 - (k % 4), 1,
                 (k % 4 == 0) ? 1 : 0, 0);
        end

        // Enable gating
        do_load(3, 1'b0, 1'b0);
        en = 1'b1; step(); outs("eg1", 2, 1, 0, 0);
        en = 1'b0; step(); outs("eg2", 2, 1, 0, 0);
        en = 1'b0; step(); outs("eg3", 2, 1, 0, 0);
        en = 1'b1; step(); outs("eg4", 1, 1, 0, 0);
        en = 1'b1; step(); outs("eg5", 0, 0, 1, 1);

        // en low on terminal cycle delays terminal
        do_load(1, 1'b0, 1'b0);
        step(); outs("tlow", 1, 1, 0, 0);
        en = 1'b1;
        step(); outs("tlow_en", 0, 0, 1, 1);

        // Zero load
        do_load(0, 1'b0, 1'b1);
        outs("zero", 0, 0, 0, 1);
        step(); outs("zero1", 0, 0, 0, 1);
        step(); outs("zero2", 0, 0, 0, 1);

        // Load collides with terminal
        do_load(2, 1'b0, 1'b1);
        step(); outs("col1", 1, 1, 0, 0);
        do_load(7, 1'b0, 1'b1);
        outs("col_ld", 7, 1, 0, 0);
        step(); outs("col2", 6, 1, 0, 0);

        // Reload value 1
        do_load(1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            outs("rl1", 1, 1, 1, 0);
        end

        // auto_reload only matters on the terminal cycle
        do_load(3, 1'b0, 1'b1);
        auto_reload = 1'b0; step(); outs("arm1", 2, 1, 0, 0);
        auto_reload = 1'b1; step(); outs("arm2", 1, 1, 0, 0);
        auto_reload = 1'b1; step(); outs("arm3", 3, 1, 1, 0);
        step(); step();
        auto_reload = 1'b0; step(); outs("arm4", 0, 0, 1, 1);

        // Full range 255
        do_load(255, 1'b0, 1'b1);
        outs("max_ld", 255, 1, 0, 0);
        tc_seen = 0;
        for (int k = 1; k < 255; k++) begin
            step();
            if (tc) tc_seen++;
            if (count != 8'(255 - k)) chk("max_seq", int'(count), 255 - k);
        end
        chk("max_no_early_tc", tc_seen, 0);
        chk("max_pre", int'(count), 1);
        step(); outs("max_tc", 0, 0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            outs("max_hold", 0, 0, 0, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
